// File: rtl/mcast_sched.sv
// mcast_sched: registers one packet and issues it to up to four of M consumer ports until all accept.
// Optional MCAST_TIMEOUT_EN abandons a packet after TIMEOUT issue cycles and counts it in drop_cnt.
module mcast_sched #(
    parameter int M       = 80,
    parameter int DATA_W  = 64,
    parameter int IDX_W   = 7,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    s_data,
    input  logic [2:0]           s_count,
    input  logic [4*IDX_W-1:0]   s_idx,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic [M-1:0]         m_valid,
    input  logic [M-1:0]         m_ready,
    output logic                 busy,
    output logic                 bad_idx,
    output logic [15:0]          drop_cnt
);
    localparam logic IDLE = 1'b0, ISSUE = 1'b1;

    logic              state_q, state_d;
    logic [M-1:0]      pending_q, pending_d, mask, left;
    logic [DATA_W-1:0] data_q, data_d;
    logic              bad_q, bad_d, bad_any, hs, tmo_hit;
    logic [2:0]        cnt;

    always_comb begin
        cnt = (s_count > 3'd4) ? 3'd4 : s_count;
        mask = '0;
        bad_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 32'(cnt)) begin
                if (32'(s_idx[i*IDX_W +: IDX_W]) < M)
                    mask = mask | (M'(1) << s_idx[i*IDX_W +: IDX_W]);
                else
                    bad_any = 1'b1;
            end
        end
    end

`ifdef MCAST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   drop_q, drop_d;

    always_comb begin
        tmo_hit = (state_q == ISSUE) && (32'(tmo_q) == TIMEOUT - 1);
        tmo_d   = (state_q == ISSUE) ? tmo_q + 1'b1 : '0;
        // a last acceptance in the timeout cycle still counts as delivered
        drop_d  = (tmo_hit && |left && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q  <= '0;
            drop_q <= '0;
        end else begin
            tmo_q  <= tmo_d;
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign tmo_hit  = 1'b0;
    assign drop_cnt = '0;
`endif

    always_comb begin
        hs        = s_valid && (state_q == IDLE);
        left      = pending_q & ~m_ready;
        state_d   = state_q;
        pending_d = pending_q;
        data_d    = data_q;
        bad_d     = 1'b0;
        if (state_q == IDLE) begin
            if (hs) begin
                data_d    = s_data;
                pending_d = mask;
                bad_d     = bad_any;
                state_d   = |mask ? ISSUE : IDLE;
            end
        end else begin
            pending_d = tmo_hit ? '0 : left;
            state_d   = (|left && !tmo_hit) ? ISSUE : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            data_q    <= '0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            bad_q     <= bad_d;
        end
    end

    always_comb begin
        s_ready = (state_q == IDLE);
        busy    = (state_q == ISSUE);
        m_valid = (state_q == ISSUE) ? pending_q : '0;
        m_data  = data_q;
        bad_idx = bad_q;
    end
endmodule

// File: tb/tb_mcast_sched.sv
// tb_mcast_sched: directed checks of mcast_sched with M=80; timeout case depends on MCAST_TIMEOUT_EN.
module tb_mcast_sched;
    localparam int M = 80;
`ifdef MCAST_TIMEOUT_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 10;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   s_data;
    logic [2:0]    s_count;
    logic [27:0]   s_idx;
    logic          s_valid;
    logic          s_ready;
    logic [63:0]   m_data;
    logic [M-1:0]  m_valid;
    logic [M-1:0]  m_ready;
    logic          busy;
    logic          bad_idx;
    logic [15:0]   drop_cnt;
    int            total = 0;
    int            bad = 0;

    mcast_sched #(.M(M), .DATA_W(64), .IDX_W(7), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_count(s_count), .s_idx(s_idx),
        .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy), .bad_idx(bad_idx), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] bit_of(input int k);
        logic [M-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic send(input logic [2:0] c, input logic [6:0] i0, input logic [6:0] i1,
                        input logic [6:0] i2, input logic [6:0] i3, input logic [63:0] d);
        s_count = c;
        s_idx   = {i3, i2, i1, i0};
        s_data  = d;
        s_valid = 1'b1;
        chk("s_ready_pre", s_ready, 1'b1);
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_count = '0; s_idx = '0; s_data = '0; m_ready = '0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_valid", m_valid, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bad_idx", bad_idx, 1'b0);
        chk("rst_drop", drop_cnt, 16'd0);
        chk("rst_m_data", m_data, 64'd0);

        // three destinations, all ready: one-cycle issue
        m_ready = '1;
        send(3'd3, 7'd5, 7'd17, 7'd79, 7'd0, 64'hDEAD_BEEF_0123_4567);
        chk("t1_valid", m_valid, bit_of(5) | bit_of(17) | bit_of(79));
        chk("t1_data", m_data, 64'hDEAD_BEEF_0123_4567);
        chk("t1_busy", busy, 1'b1);
        chk("t1_s_ready", s_ready, 1'b0);
        step();
        chk("t1_valid_off", m_valid, '0);
        chk("t1_s_ready_back", s_ready, 1'b1);

        // duplicate index, port 3 stalls while other ports' ready is ignored
        m_ready = ~bit_of(3);
        send(3'd2, 7'd3, 7'd3, 7'd0, 7'd0, 64'h1111_2222_3333_4444);
        for (int i = 0; i < HOLD; i++) begin
            chk("t2_valid_hold", m_valid, bit_of(3));
            chk("t2_data_hold", m_data, 64'h1111_2222_3333_4444);
            step();
        end
        m_ready = bit_of(3);
        chk("t2_valid_last", m_valid, bit_of(3));
        step();
        chk("t2_idle_valid", m_valid, '0);
        chk("t2_idle_ready", s_ready, 1'b1);

        // one out-of-range index among valid ones
        m_ready = '0;
        send(3'd2, 7'd10, 7'd90, 7'd0, 7'd0, 64'h5);
        chk("t3_bad_pulse", bad_idx, 1'b1);
        chk("t3_valid", m_valid, bit_of(10));
        step();
        chk("t3_bad_clear", bad_idx, 1'b0);
        m_ready = bit_of(10);
        step();
        chk("t3_idle", s_ready, 1'b1);
        send(3'd1, 7'd100, 7'd0, 7'd0, 7'd0, 64'h6);
        chk("t3b_bad_pulse", bad_idx, 1'b1);
        chk("t3b_valid", m_valid, '0);
        chk("t3b_s_ready", s_ready, 1'b1);
        chk("t3b_busy", busy, 1'b0);
        step();
        chk("t3b_bad_clear", bad_idx, 1'b0);

        // count 0 emits nothing; count 5 is treated as 4
        send(3'd0, 7'd5, 7'd6, 7'd7, 7'd8, 64'h7);
        chk("t4_cnt0_valid", m_valid, '0);
        chk("t4_cnt0_busy", busy, 1'b0);
        m_ready = '1;
        send(3'd5, 7'd20, 7'd21, 7'd22, 7'd23, 64'h8);
        chk("t4_cnt5_valid", m_valid, bit_of(20) | bit_of(21) | bit_of(22) | bit_of(23));
        step();

        // staggered acceptance
        m_ready = '0;
        send(3'd4, 7'd1, 7'd2, 7'd3, 7'd4, 64'h9);
        chk("t5_c1", m_valid, bit_of(1) | bit_of(2) | bit_of(3) | bit_of(4));
        m_ready = bit_of(1);
        step();
        chk("t5_c2", m_valid, bit_of(2) | bit_of(3) | bit_of(4));
        m_ready = bit_of(3);
        step();
        chk("t5_c3", m_valid, bit_of(2) | bit_of(4));
        m_ready = '0;
        step();
        chk("t5_c4", m_valid, bit_of(2) | bit_of(4));
        chk("t5_c4_busy", busy, 1'b1);
        m_ready = bit_of(2) | bit_of(4);
        step();
        chk("t5_done_valid", m_valid, '0);
        chk("t5_done_busy", busy, 1'b0);

        // stalled port: timeout build drops after 8 cycles, default build waits
        m_ready = '0;
        send(3'd1, 7'd7, 7'd0, 7'd0, 7'd0, 64'hA);
        for (int i = 0; i < 8; i++) begin
            chk("t6_valid", m_valid, bit_of(7));
            step();
        end
`ifdef MCAST_TIMEOUT_EN
        chk("t6_dropped_valid", m_valid, '0);
        chk("t6_drop_cnt", drop_cnt, 16'd1);
        chk("t6_busy", busy, 1'b0);
`else
        repeat (992) step();
        chk("t6_still_valid", m_valid, bit_of(7));
        chk("t6_drop_cnt", drop_cnt, 16'd0);
        m_ready = bit_of(7);
        step();
        chk("t6_released", m_valid, '0);
`endif

        // reset mid-issue with two ports pending
        m_ready = '0;
        send(3'd2, 7'd40, 7'd41, 7'd0, 7'd0, 64'hB);
        step();
        chk("t7_pre_valid", m_valid, bit_of(40) | bit_of(41));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t7_valid", m_valid, '0);
        chk("t7_s_ready", s_ready, 1'b1);
        chk("t7_drop", drop_cnt, 16'd0);
        step();
        chk("t7_valid_after", m_valid, '0);
        chk("t7_busy_after", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
